// File: rtl/com_uart_pkg.sv
// rtl/com_uart_pkg.sv - shared defaults and frame state encodings for the COM UART
package com_uart_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;
    localparam int CNT_W        = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } frame_state_t;

endpackage

// File: rtl/com_uart_rx.sv
// rtl/com_uart_rx.sv - 8N1 receiver: input synchroniser, frame FSM and shift register
module com_uart_rx
    import com_uart_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_commit,
    output logic       rx_frame_err
);

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(DIVISOR / 2);

    frame_state_t     state, state_nxt;
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             armed;
    logic             rxd_s;
    logic             tick;

    assign rxd_s   = sync[1];
    assign tick    = (cnt == '0);
    assign rx_byte = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rxd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (armed && !rxd_s)          state_nxt = ST_START;
            ST_START: if (tick)                     state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bit_idx == 3'd7)  state_nxt = ST_STOP;
            ST_STOP:  if (tick)                     state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    // armed drops after every stop bit so a held-low line reports one error only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    armed <= armed | rxd_s;
                    if (armed && !rxd_s) cnt <= DIV_HALF;
                end
                ST_START: begin
                    if (tick) begin
                        cnt     <= DIV_M1;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        cnt     <= DIV_M1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) armed <= 1'b0;
                    else      cnt   <= cnt - 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        rx_commit    = 1'b0;
        rx_frame_err = 1'b0;
        if (state == ST_STOP && tick) begin
            rx_commit    = rxd_s;
            rx_frame_err = !rxd_s;
        end
    end

endmodule

// File: rtl/com_uart.sv
// rtl/com_uart.sv - COM port endpoint: transmitter, RX holding register and status/interrupt
module com_uart
    import com_uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int DIVISOR  = CLK_FREQ / BAUD
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       com_write_ready,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    input  logic       int_com_ack,
    output logic       com_int,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       uart_txd,
    input  logic       uart_rxd
);

    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIVISOR - 1);

    frame_state_t     tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit_idx;
    logic [7:0]       tx_shreg;
    logic             tx_tick;

    logic [7:0]       rx_byte;
    logic             rx_commit;
    logic             rx_ferr;
    logic             ack_q;
    logic             ack_edge;

    com_uart_rx #(.DIVISOR(DIVISOR)) u_rx (
        .clk          (clk50M),
        .rst_n        (rst_n),
        .rxd          (uart_rxd),
        .rx_byte      (rx_byte),
        .rx_commit    (rx_commit),
        .rx_frame_err (rx_ferr)
    );

    assign tx_tick = (tx_cnt == '0);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) tx_state <= ST_IDLE;
        else        tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            ST_IDLE:  if (tx_start)                    tx_state_nxt = ST_START;
            ST_START: if (tx_tick)                     tx_state_nxt = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit_idx == 3'd7) tx_state_nxt = ST_STOP;
            ST_STOP:  if (tx_tick)                     tx_state_nxt = ST_IDLE;
            default:                                   tx_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shreg   <= '0;
        end else if (tx_state == ST_IDLE) begin
            if (tx_start) begin
                tx_shreg   <= tx_data;
                tx_cnt     <= DIV_M1;
                tx_bit_idx <= '0;
            end
        end else if (tx_tick) begin
            tx_cnt <= DIV_M1;
            if (tx_state == ST_DATA) begin
                tx_shreg   <= {1'b0, tx_shreg[7:1]};
                tx_bit_idx <= tx_bit_idx + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // line level decoded from state so reset forces txd high without a clock
    always_comb begin
        uart_txd        = 1'b1;
        com_write_ready = 1'b0;
        case (tx_state)
            ST_IDLE:  com_write_ready = 1'b1;
            ST_START: uart_txd        = 1'b0;
            ST_DATA:  uart_txd        = tx_shreg[0];
            default:  uart_txd        = 1'b1;
        endcase
    end

    assign ack_edge = int_com_ack && !ack_q;

    // a commit landing on the ack edge keeps the new byte flagged as unread
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            ack_q          <= 1'b0;
            com_data_in    <= '0;
            com_read_ready <= 1'b0;
            rx_overrun     <= 1'b0;
            rx_frame_err   <= 1'b0;
        end else begin
            ack_q        <= int_com_ack;
            rx_frame_err <= rx_ferr;
            if (rx_commit) begin
                com_data_in    <= rx_byte;
                com_read_ready <= 1'b1;
            end else if (ack_edge) begin
                com_read_ready <= 1'b0;
            end
            if (ack_edge)
                rx_overrun <= 1'b0;
            else if (rx_commit && com_read_ready)
                rx_overrun <= 1'b1;
        end
    end

    assign com_int = com_read_ready;

endmodule

// File: tb/tb_com_uart.sv
// tb/tb_com_uart.sv - directed self-checking bench for com_uart at DIVISOR=8
module tb_com_uart;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       com_write_ready;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       int_com_ack;
    logic       com_int;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       uart_txd;
    logic       uart_rxd;

    int n_cmp = 0;
    int n_err = 0;
    int fe_count = 0;
    int fe_base;

    always #5 clk50M = ~clk50M;

    com_uart #(.DIVISOR(8)) dut (
        .clk50M          (clk50M),
        .rst_n           (rst_n),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .com_write_ready (com_write_ready),
        .com_data_in     (com_data_in),
        .com_read_ready  (com_read_ready),
        .int_com_ack     (int_com_ack),
        .com_int         (com_int),
        .rx_overrun      (rx_overrun),
        .rx_frame_err    (rx_frame_err),
        .uart_txd        (uart_txd),
        .uart_rxd        (uart_rxd)
    );

    always @(negedge clk50M) if (rx_frame_err === 1'b1) fe_count++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] b, input int inj_at, input logic [7:0] inj);
        logic [9:0] frame;
        int busy;
        int bad [10];
        frame = {1'b1, b, 1'b0};
        busy  = 0;
        for (int i = 0; i < 10; i++) bad[i] = 0;
        @(negedge clk50M);
        tx_data  = b;
        tx_start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk50M);
            if (c == inj_at) begin
                tx_data  = inj;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            if (com_write_ready !== 1'b1) busy++;
            if (uart_txd !== frame[c / 8]) bad[c / 8]++;
        end
        @(negedge clk50M);
        tx_start = 1'b0;
        check_eq("tx_ready_after", {31'd0, com_write_ready}, 32'd1);
        check_eq("tx_busy_cycles", busy, 32'd80);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("tx_bit%0d_level", i), bad[i], 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int ack_at);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int c = 0; c < 80; c++) begin
            uart_rxd    = frame[c / 8];
            int_com_ack = (ack_at >= 0 && c >= ack_at && c < ack_at + 3);
            @(negedge clk50M);
        end
        uart_rxd    = 1'b1;
        int_com_ack = 1'b0;
        repeat (4) @(negedge clk50M);
    endtask

    initial begin
        int highs;
        rst_n       = 1'b0;
        tx_data     = 8'h00;
        tx_start    = 1'b0;
        int_com_ack = 1'b0;
        uart_rxd    = 1'b1;
        repeat (3) @(negedge clk50M);
        rst_n = 1'b1;
        @(negedge clk50M);
        check_eq("rst_txd", {31'd0, uart_txd}, 32'd1);
        check_eq("rst_write_ready", {31'd0, com_write_ready}, 32'd1);
        check_eq("rst_data_in", {24'd0, com_data_in}, 32'h0);
        check_eq("rst_read_ready", {31'd0, com_read_ready}, 32'd0);
        check_eq("rst_int", {31'd0, com_int}, 32'd0);
        check_eq("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check_eq("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);

        send_tx(8'hA5, -1, 8'h00);
        send_tx(8'hA5, 20, 8'h3C);
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk50M);
            if (uart_txd === 1'b1 && com_write_ready === 1'b1) highs++;
        end
        check_eq("busy_write_dropped", highs, 32'd20);

        send_rx(8'h5A, 1'b1, -1);
        check_eq("rx_data_5a", {24'd0, com_data_in}, 32'h5A);
        check_eq("rx_ready_5a", {31'd0, com_read_ready}, 32'd1);
        check_eq("rx_int_5a", {31'd0, com_int}, 32'd1);
        int_com_ack = 1'b1;
        @(negedge clk50M);
        check_eq("ack_clears_ready", {31'd0, com_read_ready}, 32'd0);
        @(negedge clk50M);
        @(negedge clk50M);
        int_com_ack = 1'b0;
        check_eq("ack_held_ready", {31'd0, com_read_ready}, 32'd0);
        check_eq("ack_keeps_data", {24'd0, com_data_in}, 32'h5A);
        repeat (2) @(negedge clk50M);

        send_rx(8'h11, 1'b1, -1);
        check_eq("ovr_first_no_flag", {31'd0, rx_overrun}, 32'd0);
        repeat (2) @(negedge clk50M);
        send_rx(8'h22, 1'b1, -1);
        check_eq("ovr_data", {24'd0, com_data_in}, 32'h22);
        check_eq("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        check_eq("ovr_ready", {31'd0, com_read_ready}, 32'd1);
        int_com_ack = 1'b1;
        @(negedge clk50M);
        int_com_ack = 1'b0;
        check_eq("ovr_ack_ready", {31'd0, com_read_ready}, 32'd0);
        check_eq("ovr_ack_flag", {31'd0, rx_overrun}, 32'd0);
        repeat (2) @(negedge clk50M);

        fe_base = fe_count;
        send_rx(8'h33, 1'b0, -1);
        repeat (10) @(negedge clk50M);
        check_eq("ferr_pulses", fe_count - fe_base, 32'd1);
        check_eq("ferr_ready", {31'd0, com_read_ready}, 32'd0);
        check_eq("ferr_data", {24'd0, com_data_in}, 32'h22);

        fe_base  = fe_count;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk50M);
        uart_rxd = 1'b1;
        repeat (100) @(negedge clk50M);
        check_eq("glitch_ready", {31'd0, com_read_ready}, 32'd0);
        check_eq("glitch_ferr", fe_count - fe_base, 32'd0);
        send_rx(8'h96, 1'b1, -1);
        check_eq("after_glitch_data", {24'd0, com_data_in}, 32'h96);

        repeat (2) @(negedge clk50M);
        send_rx(8'hC3, 1'b1, 79);
        check_eq("collide_ready", {31'd0, com_read_ready}, 32'd1);
        check_eq("collide_overrun", {31'd0, rx_overrun}, 32'd0);
        check_eq("collide_data", {24'd0, com_data_in}, 32'hC3);

        fe_base = fe_count;
        @(negedge clk50M);
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        uart_rxd = 1'b0;
        @(negedge clk50M);
        tx_start = 1'b0;
        repeat (30) @(negedge clk50M);
        check_eq("pre_rst_busy", {31'd0, com_write_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_txd", {31'd0, uart_txd}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, com_write_ready}, 32'd1);
        check_eq("mid_rst_read_ready", {31'd0, com_read_ready}, 32'd0);
        @(negedge clk50M);
        uart_rxd = 1'b1;
        @(negedge clk50M);
        rst_n = 1'b1;
        repeat (100) @(negedge clk50M);
        check_eq("post_rst_no_commit", {31'd0, com_read_ready}, 32'd0);
        check_eq("post_rst_data", {24'd0, com_data_in}, 32'h0);
        check_eq("post_rst_ferr", fe_count - fe_base, 32'd0);
        check_eq("post_rst_txd", {31'd0, uart_txd}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
